pll_lock_supervisor: RTL

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences a PLL out of reset and holds the downstream clock domain in reset
//   until the PLL has reported lock continuously for STABLE_CYCLES cycles.
//   Retries without limit: a lock wait that times out, or a lock loss while
//   running, pulses the PLL reset again.
//
// Parameters
//   PLL_RST_CYCLES : cycles pll_reset is held per attempt (>= 2)
//   LOCK_TIMEOUT   : cycles to wait for lock before retrying (>= 4)
//   STABLE_CYCLES  : consecutive synchronized-lock cycles before release (>= 2)
//
// Ports
//   clk          : free-running reference clock, the only clock
//   reset        : synchronous active-high reset
//   pll_lock     : PLL LOCK, asynchronous to clk
//   pll_reset    : PLL RESET, active-high, registered
//   sys_reset    : reset for the PLL-clocked logic, active-high, registered
//   locked       : high only while running with lock
//   relock_count : lock losses seen while running, saturates at 255
//   timeout_err  : sticky, set on any lock-wait timeout; cleared by reset only
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       locked,
    output logic [7:0] relock_count,
    output logic       timeout_err
);

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Terminal counts: the counter starts at 0 on state entry, so N cycles in
    // a state end when it reads N-1.
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             lock_s_q, lock_s_d;
    logic             pll_reset_q, pll_reset_d;
    logic             sys_reset_q, sys_reset_d;
    logic             locked_q, locked_d;
    logic [7:0]       relock_q, relock_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        // Two-flop synchronizer; only lock_s_q feeds decisions.
        sync1_d   = pll_lock;
        lock_s_d  = sync1_q;

        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        relock_d  = relock_q;
        timeout_d = timeout_q;

        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = PLL_RST;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            STABLE: begin
                // A captured low goes back to waiting without re-resetting the PLL.
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == ST_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Counter is idle here; hold it so it can never wrap.
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d = PLL_RST;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they change on the
        // same edge as the state transition.
        pll_reset_d = (state_d == PLL_RST);
        sys_reset_d = (state_d != RUN);
        locked_d    = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            relock_q    <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            lock_s_q    <= lock_s_d;
            pll_reset_q <= pll_reset_d;
            sys_reset_q <= sys_reset_d;
            locked_q    <= locked_d;
            relock_q    <= relock_d;
            timeout_q   <= timeout_d;
        end
    end

    assign pll_reset    = pll_reset_q;
    assign sys_reset    = sys_reset_q;
    assign locked       = locked_q;
    assign relock_count = relock_q;
    assign timeout_err  = timeout_q;

endmodule
